// File: rtl/cmd_pkg.sv
// Shared definitions for the telecommand frame decoder.
// Holds default header bytes, the writable register address window,
// error codes, the decoder state encoding, the register-write payload
// type and the frame checksum helper.
package cmd_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ERR_W  = 2;

  localparam logic [BYTE_W-1:0] HDR0_DEF = 8'hEB;
  localparam logic [BYTE_W-1:0] HDR1_DEF = 8'h90;

  // Decoded address window of the configuration register bank
  localparam logic [BYTE_W-1:0] ADDR_MIN = 8'h02;
  localparam logic [BYTE_W-1:0] ADDR_MAX = 8'h15;

  typedef logic [ERR_W-1:0] err_code_t;

  localparam err_code_t ERR_NONE = 2'b00;
  localparam err_code_t ERR_CSUM = 2'b01;
  localparam err_code_t ERR_TOUT = 2'b10;
  localparam err_code_t ERR_ADDR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_H1   = 3'd1,
    ST_AD   = 3'd2,
    ST_DH   = 3'd3,
    ST_DL   = 3'd4,
    ST_CS   = 3'd5
  } state_t;

  // Register write payload as seen by the register bank
  typedef struct packed {
    logic [BYTE_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } reg_wr_t;

  // Frame checksum: modulo-256 sum of address and both data bytes
  function automatic logic [BYTE_W-1:0] frame_csum(
    input logic [BYTE_W-1:0] addr,
    input logic [BYTE_W-1:0] dh,
    input logic [BYTE_W-1:0] dl
  );
    return BYTE_W'(addr + dh + dl);
  endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit counter that increments on enable and sticks at all-ones.
// Ports:
//   clk_in - clock
//   rst_in - synchronous active-high reset, clears the count
//   inc    - increment enable for this cycle
//   cnt    - registered count value
module sat_cnt16 (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        inc,
  output logic [15:0] cnt
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating count register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cmd_frame_decoder.sv
// Byte-level telecommand frame decoder feeding the config register bank.
// Frames are HDR0 HDR1 ADDR DH DL CS with CS = ADDR+DH+DL mod 256.
// Accepted frames produce a one-cycle register write; rejected or
// timed-out frames bump the error counter and the sticky error code.
// Ports:
//   clk_in            - clock
//   rst_in            - synchronous active-high reset
//   byte_vld_in       - one-cycle strobe for a received byte
//   byte_in           - received byte
//   wr_out            - one-cycle register write strobe
//   wr_addr_out       - last accepted register address
//   data_out          - last accepted register data
//   frame_ok_cnt_out  - accepted frame count (saturating)
//   frame_err_cnt_out - rejected frame count (saturating)
//   err_code_out      - last error code
module cmd_frame_decoder
  import cmd_pkg::*;
#(
  parameter int unsigned      TIMEOUT_CYC = 5000,
  parameter logic [7:0]       HDR0        = HDR0_DEF,
  parameter logic [7:0]       HDR1        = HDR1_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        byte_vld_in,
  input  logic [7:0]  byte_in,
  output logic        wr_out,
  output logic [7:0]  wr_addr_out,
  output logic [15:0] data_out,
  output logic [15:0] frame_ok_cnt_out,
  output logic [15:0] frame_err_cnt_out,
  output logic [1:0]  err_code_out
);

  localparam int unsigned GAP_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  reg_wr_t           shadow_q, shadow_d;
  logic              wr_q, wr_d;
  reg_wr_t           out_q, out_d;
  err_code_t         err_code_q, err_code_d;
  logic              ok_inc_c;
  logic              err_inc_c;
  logic              in_frame_c;
  logic              addr_ok_c;

  assign in_frame_c = (state_q == ST_AD) || (state_q == ST_DH) ||
                      (state_q == ST_DL) || (state_q == ST_CS);
  assign addr_ok_c  = (shadow_q.addr >= ADDR_MIN) && (shadow_q.addr <= ADDR_MAX);

  // State and datapath registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      shadow_q   <= '0;
      wr_q       <= 1'b0;
      out_q      <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      shadow_q   <= shadow_d;
      wr_q       <= wr_d;
      out_q      <= out_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state, frame evaluation and timeout
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    shadow_d   = shadow_q;
    wr_d       = 1'b0;
    out_d      = out_q;
    err_code_d = err_code_q;
    ok_inc_c   = 1'b0;
    err_inc_c  = 1'b0;

    if (byte_vld_in) begin
      // A byte always wins over a timeout on the same cycle
      gap_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (byte_in == HDR0) state_d = ST_H1;
        end
        ST_H1: begin
          // Repeated HDR0 keeps us waiting for HDR1 (resync)
          if (byte_in == HDR1) begin
            state_d = ST_AD;
          end else if (byte_in != HDR0) begin
            state_d = ST_IDLE;
          end
        end
        ST_AD: begin
          shadow_d.addr = byte_in;
          state_d       = ST_DH;
        end
        ST_DH: begin
          shadow_d.data[15:8] = byte_in;
          state_d             = ST_DL;
        end
        ST_DL: begin
          shadow_d.data[7:0] = byte_in;
          state_d            = ST_CS;
        end
        ST_CS: begin
          state_d = ST_IDLE;
          if (byte_in != frame_csum(shadow_q.addr, shadow_q.data[15:8], shadow_q.data[7:0])) begin
            err_inc_c  = 1'b1;
            err_code_d = ERR_CSUM;
          end else if (!addr_ok_c) begin
            err_inc_c  = 1'b1;
            err_code_d = ERR_ADDR;
          end else begin
            ok_inc_c = 1'b1;
            wr_d     = 1'b1;
            out_d    = shadow_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (in_frame_c) begin
      if (gap_q == GAP_LAST) begin
        state_d    = ST_IDLE;
        gap_d      = '0;
        err_inc_c  = 1'b1;
        err_code_d = ERR_TOUT;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end
  end

  sat_cnt16 u_ok_cnt (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc    (ok_inc_c),
    .cnt    (frame_ok_cnt_out)
  );

  sat_cnt16 u_err_cnt (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc    (err_inc_c),
    .cnt    (frame_err_cnt_out)
  );

  assign wr_out       = wr_q;
  assign wr_addr_out  = out_q.addr;
  assign data_out     = out_q.data;
  assign err_code_out = err_code_q;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Testbench for cmd_frame_decoder: directed test-plan frames followed by
// randomized frames, all compared each cycle against a byte-queue model.
module tb_cmd_frame_decoder;

  localparam int unsigned T  = 16;
  localparam logic [7:0]  H0 = 8'hEB;
  localparam logic [7:0]  H1 = 8'h90;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        byte_vld_in;
  logic [7:0]  byte_in;
  logic        wr_out;
  logic [7:0]  wr_addr_out;
  logic [15:0] data_out;
  logic [15:0] frame_ok_cnt_out;
  logic [15:0] frame_err_cnt_out;
  logic [1:0]  err_code_out;

  int n_assert = 0;
  int n_fail   = 0;

  cmd_frame_decoder #(
    .TIMEOUT_CYC (T),
    .HDR0        (H0),
    .HDR1        (H1)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .byte_vld_in       (byte_vld_in),
    .byte_in           (byte_in),
    .wr_out            (wr_out),
    .wr_addr_out       (wr_addr_out),
    .data_out          (data_out),
    .frame_ok_cnt_out  (frame_ok_cnt_out),
    .frame_err_cnt_out (frame_err_cnt_out),
    .err_code_out      (err_code_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: header tracking plus a queue of post-header bytes
  bit         m_hdr0_seen;
  bit         m_locked;
  logic [7:0] m_q[$];
  int         m_idle;
  logic       e_wr;
  logic [7:0] e_addr;
  logic [15:0] e_data;
  int         e_ok;
  int         e_err;
  logic [1:0] e_code;

  function automatic void model_reset();
    m_hdr0_seen = 1'b0;
    m_locked    = 1'b0;
    m_q.delete();
    m_idle      = 0;
    e_wr        = 1'b0;
    e_addr      = 8'h00;
    e_data      = 16'h0000;
    e_ok        = 0;
    e_err       = 0;
    e_code      = 2'b00;
  endfunction

  function automatic void model_reject(input logic [1:0] code);
    if (e_err < 65535) e_err++;
    e_code = code;
  endfunction

  function automatic void model_eval();
    int sum;
    sum = (int'(m_q[0]) + int'(m_q[1]) + int'(m_q[2])) % 256;
    if (sum != int'(m_q[3])) begin
      model_reject(2'b01);
    end else if (int'(m_q[0]) < 2 || int'(m_q[0]) > 21) begin
      model_reject(2'b11);
    end else begin
      e_wr   = 1'b1;
      e_addr = m_q[0];
      e_data = {m_q[1], m_q[2]};
      if (e_ok < 65535) e_ok++;
    end
  endfunction

  function automatic void model_step(input bit vld, input logic [7:0] b);
    e_wr = 1'b0;
    if (m_locked) begin
      if (vld) begin
        m_q.push_back(b);
        m_idle = 0;
        if (m_q.size() == 4) begin
          model_eval();
          m_q.delete();
          m_locked = 1'b0;
        end
      end else begin
        m_idle++;
        if (m_idle == int'(T)) begin
          model_reject(2'b10);
          m_q.delete();
          m_locked = 1'b0;
          m_idle   = 0;
        end
      end
    end else if (vld) begin
      if (m_hdr0_seen && b == H1) begin
        m_locked    = 1'b1;
        m_hdr0_seen = 1'b0;
        m_idle      = 0;
        m_q.delete();
      end else begin
        m_hdr0_seen = (b == H0);
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("wr_out",       32'(wr_out),            32'(e_wr));
    check("wr_addr_out",  32'(wr_addr_out),       32'(e_addr));
    check("data_out",     32'(data_out),          32'(e_data));
    check("ok_cnt",       32'(frame_ok_cnt_out),  32'(e_ok));
    check("err_cnt",      32'(frame_err_cnt_out), 32'(e_err));
    check("err_code",     32'(err_code_out),      32'(e_code));
  endtask

  // One clock cycle with optional byte; checks all outputs after the edge
  task automatic step(input bit vld, input logic [7:0] b);
    byte_vld_in = vld;
    byte_in     = vld ? b : 8'($urandom);
    model_step(vld, b);
    @(posedge clk_in);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst_in      = 1'b1;
    byte_vld_in = 1'b0;
    byte_in     = 8'h00;
    model_reset();
    @(posedge clk_in);
    #1;
    check_all();
    rst_in = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl,
                            input logic [7:0] cs, input int maxgap);
    send(H0);  idle($urandom_range(0, maxgap));
    send(H1);  idle($urandom_range(0, maxgap));
    send(a);   idle($urandom_range(0, maxgap));
    send(dh);  idle($urandom_range(0, maxgap));
    send(dl);  idle($urandom_range(0, maxgap));
    send(cs);
  endtask

  initial begin
    logic [7:0] a, dh, dl, cs;
    int kind;
    rst_in      = 1'b1;
    byte_vld_in = 1'b0;
    byte_in     = 8'h00;
    model_reset();

    // Reset state
    do_reset();
    check("rst_wr",   32'(wr_out),            32'h0);
    check("rst_addr", 32'(wr_addr_out),       32'h0);
    check("rst_code", 32'(err_code_out),      32'h0);
    check("rst_err",  32'(frame_err_cnt_out), 32'h0);

    // Good frame
    send(8'hEB); send(8'h90); send(8'h02); send(8'h00); send(8'h01); send(8'h03);
    check("tp_good_wr",   32'(wr_out),           32'h1);
    check("tp_good_addr", 32'(wr_addr_out),      32'h02);
    check("tp_good_data", 32'(data_out),         32'h0001);
    check("tp_good_ok",   32'(frame_ok_cnt_out), 32'h1);
    idle(1);
    check("tp_good_wr_1cyc", 32'(wr_out), 32'h0);

    // Bad checksum
    send(8'hEB); send(8'h90); send(8'h04); send(8'h12); send(8'h34); send(8'h00);
    check("tp_csum_wr",   32'(wr_out),            32'h0);
    check("tp_csum_code", 32'(err_code_out),      32'h1);
    check("tp_csum_err",  32'(frame_err_cnt_out), 32'h1);
    check("tp_csum_data", 32'(data_out),          32'h0001);
    idle(2);

    // Address out of range
    send(8'hEB); send(8'h90); send(8'h20); send(8'h00); send(8'h00); send(8'h20);
    check("tp_addr_code", 32'(err_code_out),      32'h3);
    check("tp_addr_err",  32'(frame_err_cnt_out), 32'h2);
    check("tp_addr_addr", 32'(wr_addr_out),       32'h02);

    // Timeout, then a good frame
    send(8'hEB); send(8'h90); send(8'h05);
    idle(T - 1);
    check("tp_tout_early", 32'(err_code_out), 32'h3);
    idle(1);
    check("tp_tout_code", 32'(err_code_out),      32'h2);
    check("tp_tout_err",  32'(frame_err_cnt_out), 32'h3);
    idle(3);
    send(8'hEB); send(8'h90); send(8'h07); send(8'h12); send(8'h34); send(8'h4D);
    check("tp_after_tout_wr",   32'(wr_out),       32'h1);
    check("tp_after_tout_addr", 32'(wr_addr_out),  32'h07);
    check("tp_sticky_code",     32'(err_code_out), 32'h2);

    // Resync and back-to-back frames
    send(8'hEB); send(8'hEB); send(8'h90); send(8'h03); send(8'h00); send(8'h55); send(8'h58);
    check("tp_b2b1_wr",   32'(wr_out),      32'h1);
    check("tp_b2b1_addr", 32'(wr_addr_out), 32'h03);
    check("tp_b2b1_data", 32'(data_out),    32'h0055);
    send(8'hEB);
    send(8'h90); send(8'h03); send(8'h00); send(8'h60); send(8'h63);
    check("tp_b2b2_wr",   32'(wr_out),           32'h1);
    check("tp_b2b2_data", 32'(data_out),         32'h0060);
    check("tp_b2b2_ok",   32'(frame_ok_cnt_out), 32'h4);

    // Reset in the middle of a frame
    send(8'hEB); send(8'h90); send(8'h03); send(8'h00);
    do_reset();
    check("tp_rst_ok",   32'(frame_ok_cnt_out), 32'h0);
    check("tp_rst_data", 32'(data_out),         32'h0);
    send(8'h60); send(8'h63);
    check("tp_rst_nowr", 32'(wr_out), 32'h0);

    // Randomized frames against the model
    for (int f = 0; f < 300; f++) begin
      kind = $urandom_range(0, 6);
      a    = 8'($urandom_range(0, 23));
      dh   = 8'($urandom);
      dl   = 8'($urandom);
      cs   = 8'(a + dh + dl);
      case (kind)
        0, 1: send_frame(a, dh, dl, cs, 2);
        2:    send_frame(a, dh, dl, cs ^ 8'(1 << $urandom_range(0, 7)), 2);
        3:    for (int i = 0; i < int'($urandom_range(1, 4)); i++) send(8'($urandom));
        4: begin
          send(H0); send(H1);
          for (int i = 0; i < int'($urandom_range(0, 3)); i++) send(8'($urandom));
          idle(T + $urandom_range(0, 3));
        end
        5: begin
          send(H0); send(H1); send(a);
          idle(T - 1);
          send(dh); send(dl); send(cs);
        end
        default: send_frame(a, dh, dl, cs, 0);
      endcase
      idle($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
